// File: rtl/bip_accumulator_if.sv
// Request/result bundle of the BIP accumulator.
// The master side is the control unit and result consumer; the slave side is the accumulator.
interface bip_accumulator_if #(
   parameter int WIDTH = 11
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] acc;
   logic             ovf;

   modport master (
      output in_valid, op, operand, out_ready,
      input  in_ready, out_valid, acc, ovf
   );

   modport slave (
      input  in_valid, op, operand, out_ready,
      output in_ready, out_valid, acc, ovf
   );
endinterface

// File: rtl/bip_accumulator.sv
// Accumulator unit for the BIP datapath.
// A two-stage pipe: S1 holds the accepted request, S2 is the accumulator/result register
// published with a valid/ready handshake. LD, ADD, SUB and CLR are applied to the signed accumulator.
// Build option BIP_ACC_SAT_EN: when defined, ADD/SUB overflow saturates acc to the signed
// extreme instead of wrapping; ovf is raised in both builds.
module bip_accumulator #(
   parameter int WIDTH = 11
) (
   input  logic                clk,
   input  logic                reset,
   bip_accumulator_if.slave    bus
);

   typedef enum logic [1:0] {
      OP_LD  = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_CLR = 2'b11
   } op_e;

`ifdef BIP_ACC_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   // S1: request register
   logic             s1_valid_reg;
   op_e              s1_op_reg;
   logic [WIDTH-1:0] s1_operand_reg;

   // S2: result register
   logic [WIDTH-1:0] acc_reg;
   logic             ovf_reg;
   logic             out_valid_reg;

   logic [WIDTH-1:0] acc_next;
   logic             ovf_next;
   logic [WIDTH:0]   ext_sum;

   logic advance;
   logic in_ready_int;
   logic accept;
   logic commit;

   // S2 can take a new result when it is empty or its current result is being consumed.
   assign advance      = !out_valid_reg || bus.out_ready;
   assign in_ready_int = !reset && (!s1_valid_reg || advance);
   assign accept       = bus.in_valid && in_ready_int;
   assign commit       = s1_valid_reg && advance;

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_reg;
   assign bus.acc       = acc_reg;
   assign bus.ovf       = ovf_reg;

   // Result of the op waiting in S1 against the current accumulator (one extra bit to see overflow).
   always_comb begin
      ext_sum  = '0;
      acc_next = acc_reg;
      ovf_next = 1'b0;
      case (s1_op_reg)
         OP_LD: begin
            acc_next = s1_operand_reg;
         end
         OP_CLR: begin
            acc_next = '0;
         end
         OP_ADD, OP_SUB: begin
            if (s1_op_reg == OP_ADD) begin
               ext_sum = {acc_reg[WIDTH-1], acc_reg} + {s1_operand_reg[WIDTH-1], s1_operand_reg};
            end else begin
               ext_sum = {acc_reg[WIDTH-1], acc_reg} - {s1_operand_reg[WIDTH-1], s1_operand_reg};
            end
            ovf_next = ext_sum[WIDTH] ^ ext_sum[WIDTH-1];
            acc_next = ext_sum[WIDTH-1:0];
`ifdef BIP_ACC_SAT_EN
            // The extended sign bit is the true sign of the exact result.
            if (ovf_next) begin
               acc_next = ext_sum[WIDTH] ? SAT_MIN : SAT_MAX;
            end
`endif
         end
         default: begin
            acc_next = acc_reg;
         end
      endcase
   end

   // S1 fills on accept and empties when its op commits; both can happen on one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg   <= 1'b0;
         s1_op_reg      <= OP_LD;
         s1_operand_reg <= '0;
      end else if (accept) begin
         s1_valid_reg   <= 1'b1;
         s1_op_reg      <= op_e'(bus.op);
         s1_operand_reg <= bus.operand;
      end else if (commit) begin
         s1_valid_reg   <= 1'b0;
      end
   end

   // S2 takes the committed result; a consumed result with no replacement clears out_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg       <= '0;
         ovf_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (commit) begin
         acc_reg       <= acc_next;
         ovf_reg       <= ovf_next;
         out_valid_reg <= 1'b1;
      end else if (out_valid_reg && bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bip_accumulator.sv
// Self-checking bench for bip_accumulator: directed scenarios plus randomized ops with
// random backpressure, checked by a scoreboard fed from an arithmetic reference model.
module tb_bip_accumulator;

   localparam int W    = 11;
   localparam int MAXV = 1023;
   localparam int MINV = -1024;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bip_accumulator_if #(.WIDTH(W)) bus ();

   bip_accumulator #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int acc;
      bit ovf;
   } res_t;

   int   total = 0;
   int   bad   = 0;
   res_t exp_q[$];

   // consumer side: directed value or random backpressure
   bit   rand_bp   = 1'b0;
   logic ready_cmd = 1'b1;
   logic rnd_ready = 1'b1;
   assign bus.out_ready = rand_bp ? rnd_ready : ready_cmd;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rnd_ready = ($urandom_range(0, 99) < 65);
      end
   end

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic chk(input string name, input int got, input int expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
      end
   endtask

   // Reference: exact integer arithmetic, then wrap or clamp into the 11-bit signed range.
   function automatic res_t ref_step(input int cur, input logic [1:0] op, input int v);
      res_t r;
      int   s;
      r.ovf = 1'b0;
      r.acc = 0;
      case (op)
         2'd0: r.acc = v;
         2'd3: r.acc = 0;
         default: begin
            s = (op == 2'd1) ? cur + v : cur - v;
            if (s > MAXV || s < MINV) begin
               r.ovf = 1'b1;
`ifdef BIP_ACC_SAT_EN
               r.acc = (s > MAXV) ? MAXV : MINV;
`else
               r.acc = (s > MAXV) ? s - 2048 : s + 2048;
`endif
            end else begin
               r.acc = s;
            end
         end
      endcase
      return r;
   endfunction

   // Scoreboard: push on accept, pop on every fresh result, and check that acc/ovf hold otherwise.
   int   model_acc = 0;
   bit   prev_ov = 1'b0;
   bit   prev_or = 1'b0;
   int   last_acc = 0;
   bit   last_ovf = 1'b0;
   int   cur_acc;
   res_t sb_e;
   res_t sb_r;
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         model_acc = 0;
         prev_ov   = 1'b0;
         prev_or   = 1'b0;
         last_acc  = 0;
         last_ovf  = 1'b0;
      end else begin
         cur_acc = sx(bus.acc);
         if (bus.out_valid && (!prev_ov || prev_or)) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got acc=%0d with no pending request, expected none", cur_acc);
            end else begin
               sb_e = exp_q.pop_front();
               chk("sb_acc", cur_acc, sb_e.acc);
               chk("sb_ovf", int'(bus.ovf), int'(sb_e.ovf));
               $display("result acc=%0d ovf=%0d", cur_acc, bus.ovf);
            end
         end else begin
            chk("hold_acc", cur_acc, last_acc);
            chk("hold_ovf", int'(bus.ovf), int'(last_ovf));
         end
         last_acc = cur_acc;
         last_ovf = bus.ovf;
         prev_ov  = bus.out_valid;
         prev_or  = bus.out_ready;
         if (bus.in_valid && bus.in_ready) begin
            sb_r = ref_step(model_acc, bus.op, sx(bus.operand));
            model_acc = sb_r.acc;
            exp_q.push_back(sb_r);
         end
      end
   end

   // Present one request and hold it until accepted (bounded); returns 1ns after the accepting edge.
   task automatic issue(input logic [1:0] op, input int v);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.operand  = v[W-1:0];
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 300 cycles");
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Issue with out_ready high and check the value committed one edge later.
   task automatic run_op(input string name, input logic [1:0] op, input int v,
                         input int exp_acc, input bit exp_ovf);
      issue(op, v);
      @(posedge clk);
      #1;
      chk({name, "_acc"}, sx(bus.acc), exp_acc);
      chk({name, "_ovf"}, int'(bus.ovf), int'(exp_ovf));
      $display("op=%0d operand=%0d -> acc=%0d ovf=%0d", op, v, sx(bus.acc), bus.ovf);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int v;
      int wait_cnt;
      logic [1:0] rop;

      bus.in_valid = 1'b1;
      bus.op       = 2'd0;
      bus.operand  = 11'd5;
      reset        = 1'b1;

      // reset held with in_valid high
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_in_ready", int'(bus.in_ready), 0);
         chk("rst_out_valid", int'(bus.out_valid), 0);
         chk("rst_acc", sx(bus.acc), 0);
         chk("rst_ovf", int'(bus.ovf), 0);
         @(posedge clk);
         #1;
      end
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(bus.in_ready), 1);

      // back-to-back LD 100, ADD 25, SUB 200
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1; bus.op = 2'd0; bus.operand = 11'd100;
      @(posedge clk);
      #1;
      bus.op = 2'd1; bus.operand = 11'd25;
      @(posedge clk);
      #1;
      chk("b2b_acc1", sx(bus.acc), 100);
      chk("b2b_ov1", int'(bus.out_valid), 1);
      v = 200;
      bus.op = 2'd2; bus.operand = v[W-1:0];
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("b2b_acc2", sx(bus.acc), 125);
      chk("b2b_ov2", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      chk("b2b_acc3", sx(bus.acc), -75);
      chk("b2b_ov3", int'(bus.out_valid), 1);
      chk("b2b_ovf3", int'(bus.ovf), 0);
      @(posedge clk);
      #1;
      chk("b2b_drained", int'(bus.out_valid), 0);

      // overflow boundaries
      run_op("pos_ld", 2'd0, 1000, 1000, 1'b0);
`ifdef BIP_ACC_SAT_EN
      run_op("pos_ovf", 2'd1, 100, 1023, 1'b1);
`else
      run_op("pos_ovf", 2'd1, 100, -948, 1'b1);
`endif
      run_op("after_ld", 2'd0, 5, 5, 1'b0);
      run_op("neg_ld", 2'd0, -1024, -1024, 1'b0);
`ifdef BIP_ACC_SAT_EN
      run_op("neg_ovf", 2'd2, 1, -1024, 1'b1);
`else
      run_op("neg_ovf", 2'd2, 1, 1023, 1'b1);
`endif
      run_op("clr", 2'd3, 77, 0, 1'b0);
      run_op("edge_add", 2'd1, 1023, 1023, 1'b0);

      // backpressure
      idle(2);
      issue(2'd0, 7);
      ready_cmd = 1'b0;
      issue(2'd1, 1);
      bus.in_valid = 1'b1; bus.op = 2'd0; bus.operand = 11'd500;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_acc", sx(bus.acc), 7);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         chk("bp_out_valid", int'(bus.out_valid), 1);
      end
      @(posedge clk);
      #1;
      ready_cmd    = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_release_acc", sx(bus.acc), 8);
      chk("bp_release_ov", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      chk("bp_drained", int'(bus.out_valid), 0);

      // reset with S1 and S2 both full
      idle(2);
      ready_cmd = 1'b0;
      issue(2'd0, 3);
      issue(2'd1, 4);
      @(negedge clk);
      chk("mid_full_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_acc", sx(bus.acc), 0);
      chk("mid_rst_ov", int'(bus.out_valid), 0);
      reset     = 1'b0;
      ready_cmd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_replay_ov", int'(bus.out_valid), 0);
         chk("mid_no_replay_acc", sx(bus.acc), 0);
      end

      // randomized ops under random backpressure
      rand_bp = 1'b1;
      for (int n = 0; n < 400; n++) begin
         idle(int'($urandom_range(0, 2)));
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: v = ($urandom_range(0, 1) == 1) ? MAXV : MINV;
            1: v = int'($urandom_range(0, 8)) - 4;
            default: v = int'($urandom_range(0, 2047)) - 1024;
         endcase
         issue(rop, v);
      end
      rand_bp   = 1'b0;
      ready_cmd = 1'b1;
      wait_cnt  = 0;
      while (exp_q.size() != 0 && wait_cnt < 50) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      chk("drain_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bip_accumulator.md
# bip_accumulator

Accumulator unit for the BIP datapath. It holds the processor's signed 11-bit accumulator and applies LD, ADD, SUB and CLR operations presented by the control unit through a valid/ready handshake. The operand comes from data memory or an immediate. Each result is published through a registered output with backpressure, so it pairs with the combinational subtractor as the stateful end of the arithmetic path.

## Interface
Parameters:
- WIDTH, 11: accumulator, operand and result width, two's complement.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  2  operation: 00 LD, 01 ADD, 10 SUB, 11 CLR.
- operand  input  WIDTH  signed operand; ignored for CLR.
- out_valid  output  1  a fresh result is present on acc/ovf.
- out_ready  input  1  consumer accepts the current result.
- acc  output  WIDTH  accumulator register, signed.
- ovf  output  1  signed overflow of the last completed operation.

## Operation
- Stage S1 is the request register: s1_valid, s1_op, s1_operand.
- Stage S2 is the output register: acc, ovf, out_valid.
- Accept: in_valid && in_ready at an edge loads S1.
- in_ready = !reset && (!s1_valid || advance).
- advance = !out_valid || out_ready.
- Commit: s1_valid && advance at an edge writes acc and ovf, sets out_valid = 1 and frees S1. S1 may be refilled at the same edge.
- Drain: out_valid && out_ready with no commit clears out_valid at that edge. acc holds its value.
- Result is computed combinationally from the current acc and S1:
  - LD: acc ← operand; ovf ← 0.
  - CLR: acc ← 0; ovf ← 0.
  - ADD: WIDTH+1-bit sum acc + operand.
  - SUB: WIDTH+1-bit difference acc − operand.
- ADD/SUB: ovf = 1 when the top two bits of the WIDTH+1 result differ. Default behaviour on overflow: acc takes the low WIDTH bits (wrap).
- No data hazard on back-to-back ops. The op in S1 always reads an acc that already includes every earlier commit.
- Stall: with out_valid=1 and out_ready=0, S2 holds and S1 holds. in_ready=0 when S1 is full. operand and op changes while in_ready=0 have no effect.
- Reset:
  - acc=0, ovf=0, out_valid=0, s1_valid=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after it.
  - Reset mid-stall discards pending S1 and S2 contents; nothing is replayed.

## Timing
- Latency: a request accepted at edge N commits at edge N+1 when out_ready is high (or out_valid is low) in cycle N+1. out_valid is seen high in cycle N+1.
- Throughput: one op per cycle while out_ready stays high.
- Each commit asserts out_valid for at least one cycle. It stays high until an edge where out_ready=1 and no new commit occurs.
- Simultaneous drain and commit at one edge: out_valid remains 1 and the new value replaces the old.
- acc is a plain register output with no combinational path from the inputs. in_ready combinationally depends on out_ready.

## Configuration
- BIP_ACC_SAT_EN defined: on ADD/SUB overflow, acc saturates to +2^(WIDTH−1)−1 for positive overflow or −2^(WIDTH−1) for negative overflow (1023/−1024 at WIDTH=11). ovf=1.
- BIP_ACC_SAT_EN undefined: acc wraps modulo 2^WIDTH; ovf=1.
- No other behaviour differs between the two builds.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 → acc=0, ovf=0, out_valid=0, in_ready=0 throughout; in_ready=1 in the first cycle after.
- Back-to-back with out_ready=1: LD 100, ADD 25, SUB 200 on consecutive cycles → acc 100, 125, −75 in cycles N+1, N+2, N+3; out_valid high for 3 cycles; ovf=0.
- Positive overflow: LD 1000, ADD 100.
  - Wrap build: acc=−948, ovf=1.
  - BIP_ACC_SAT_EN build: acc=1023, ovf=1.
  - A following LD 5 gives acc=5, ovf=0.
- Negative overflow: LD −1024, SUB 1.
  - Wrap build: acc=1023, ovf=1.
  - Saturating build: acc=−1024, ovf=1.
- Backpressure: out_ready=0 after LD 7.
  - Then ADD 1 is accepted into S1; in_ready drops; acc stays 7 for 5 cycles.
  - Raising out_ready commits acc=8 at the next edge, with out_valid still 1.
- Reset mid-stall: assert reset with S1 and S2 both full → next cycle acc=0, out_valid=0, and no stale commit follows.
